// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC UART packer: serializer states, packet layout
// and the packet checksum.
`default_nettype none

package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ser_state_t;

  localparam int          PKT_BYTES     = 6;
  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hAA;
  localparam int          TIME1_LSB     = 0;
  localparam int          CALIB_LSB     = 16;
  localparam int          FIFO_DW       = 32;

  // Stored word layout is {calib_diff, time1}; checksum is the XOR of its bytes.
  function automatic logic [7:0] pkt_chk(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_uart_packer_if.sv
// Producer handshake, UART transmit and FIFO status signals of the packer.
`default_nettype none

interface tdc_uart_packer_if #(
  parameter int FIFO_AW = 4
);

  logic              w_wr_en;
  logic [47:0]       data_TO_FIFO;
  logic              fifo_writing_done;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_new_data;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  modport master (
    output w_wr_en, data_TO_FIFO, tx_busy,
    input  fifo_writing_done, tx_data, tx_new_data,
    input  fifo_count, fifo_full, fifo_empty
  );

  modport slave (
    input  w_wr_en, data_TO_FIFO, tx_busy,
    output fifo_writing_done, tx_data, tx_new_data,
    output fifo_count, fifo_full, fifo_empty
  );

endinterface

`default_nettype wire

// File: rtl/tdc_sync_fifo.sv
// Synchronous FIFO with registered read data (one-cycle latency) and occupancy count.
`default_nettype none

module tdc_sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_push,
  input  wire logic [DW-1:0] i_din,
  input  wire logic          i_pop,
  output logic      [DW-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty,
  output logic      [AW:0]   o_count
);

  localparam int           DEPTH   = 1 << AW;
  localparam logic [AW:0]  DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic          w_push;
  logic          w_pop;

  // Full/empty come from the registered count, so a push never relies on a same-cycle pop.
  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_dout;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdc_uart_packer.sv
// Captures TDC measurement words into a FIFO and streams each as a 6-byte
// packet (sync, time1, calib_diff, checksum) to a UART transmitter.
`default_nettype none

import tdc_pkg::*;

module tdc_uart_packer #(
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  wire logic         clk,
  input  wire logic         rst,
  tdc_uart_packer_if.slave  s_bus
);

  logic               r_armed;
  logic               r_done;
  logic               w_capture;
  logic [FIFO_DW-1:0] w_fifo_din;
  logic [FIFO_DW-1:0] w_fifo_dout;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [FIFO_AW:0]   w_fifo_count;
  logic               w_unused_hi;

  ser_state_t         r_state;
  ser_state_t         w_state_nxt;
  logic               w_pop;
  logic               w_issue;
  logic [2:0]         r_byte_idx;
  logic [15:0]        r_time1;
  logic [15:0]        r_calib;
  logic [7:0]         r_chk;
  logic [7:0]         w_byte;
  logic [7:0]         r_tx_data;
  logic               r_tx_new;

  assign w_capture   = s_bus.w_wr_en && r_armed && !w_fifo_full;
  assign w_fifo_din  = {s_bus.data_TO_FIFO[CALIB_LSB +: 16], s_bus.data_TO_FIFO[TIME1_LSB +: 16]};
  assign w_unused_hi = ^s_bus.data_TO_FIFO[47:32];

  // One push per request: disarm on capture, re-arm only once the enable is seen low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_capture) begin
        r_armed <= 1'b0;
      end else if (!s_bus.w_wr_en) begin
        r_armed <= 1'b1;
      end
    end
  end

  tdc_sync_fifo #(
    .AW (FIFO_AW),
    .DW (FIFO_DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_capture),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The !r_tx_new term keeps strobes a cycle apart so tx_busy can rise in between.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!s_bus.tx_busy && !r_tx_new) begin
          w_issue = 1'b1;
          if (r_byte_idx == 3'(PKT_BYTES - 1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_byte = SYNC_BYTE;
    case (r_byte_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = r_time1[15:8];
      3'd2:    w_byte = r_time1[7:0];
      3'd3:    w_byte = r_calib[15:8];
      3'd4:    w_byte = r_calib[7:0];
      3'd5:    w_byte = r_chk;
      default: w_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_new   <= 1'b0;
      r_tx_data  <= '0;
      r_byte_idx <= '0;
      r_time1    <= '0;
      r_calib    <= '0;
      r_chk      <= '0;
    end else begin
      r_tx_new <= w_issue;
      if (r_state == ST_LOAD) begin
        r_time1    <= w_fifo_dout[15:0];
        r_calib    <= w_fifo_dout[31:16];
        r_chk      <= pkt_chk(w_fifo_dout);
        r_byte_idx <= '0;
      end
      if (w_issue) begin
        r_tx_data  <= w_byte;
        r_byte_idx <= r_byte_idx + 1'b1;
      end
    end
  end

  assign s_bus.fifo_writing_done = r_done;
  assign s_bus.tx_data           = r_tx_data;
  assign s_bus.tx_new_data       = r_tx_new;
  assign s_bus.fifo_count        = w_fifo_count;
  assign s_bus.fifo_full         = w_fifo_full;
  assign s_bus.fifo_empty        = w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_tdc_uart_packer.sv
// Scoreboard bench: expected packet bytes are queued per written word and
// checked by a monitor on every tx_new_data strobe.
`default_nettype none

module tb_tdc_uart_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tdc_uart_packer_if #(.FIFO_AW(4)) bus ();

  tdc_uart_packer #(
    .FIFO_AW   (4),
    .SYNC_BYTE (8'hAA)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  int  n_strobes  = 0;
  int  done_cnt   = 0;
  int  exp_done   = 0;
  int  peak_count = 0;
  bit  prev_new   = 0;
  bit  prev_done  = 0;
  logic busy_q    = 1'b0;

  int  busy_min   = 0;
  int  busy_max   = 0;
  bit  busy_force = 0;
  int  busy_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference packet built straight from the field definitions.
  function automatic void push_expected(input logic [47:0] d);
    logic [15:0] t1;
    logic [15:0] cd;
    t1 = d[15:0];
    cd = d[31:16];
    exp_q.push_back(8'hAA);
    exp_q.push_back(t1[15:8]);
    exp_q.push_back(t1[7:0]);
    exp_q.push_back(cd[15:8]);
    exp_q.push_back(cd[7:0]);
    exp_q.push_back(t1[15:8] ^ t1[7:0] ^ cd[15:8] ^ cd[7:0]);
  endfunction

  always @(posedge clk) busy_q <= bus.tx_busy;

  // UART model: busy for a random number of cycles after each strobe.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) busy_cnt = 0;
      else if (bus.tx_new_data) busy_cnt = $urandom_range(busy_max, busy_min);
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = busy_force || (busy_cnt > 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.tx_new_data) begin
        n_strobes++;
        checks++;
        if (busy_q || prev_new) begin
          errors++;
          $display("FAIL strobe_gap: strobe with busy=%0d prev_strobe=%0d, expected neither", busy_q, prev_new);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no strobe", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(bus.tx_data), 32'(e));
        end
      end
      if (rst && bus.fifo_writing_done) begin
        done_cnt++;
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_width: done high 2 cycles, expected 1");
        end
      end
      prev_new  = bus.tx_new_data;
      prev_done = bus.fifo_writing_done;
      if (int'(bus.fifo_count) > peak_count) peak_count = int'(bus.fifo_count);
    end
  end

  task automatic send_word(input logic [47:0] d, input int hold);
    bit got;
    got = 0;
    push_expected(d);
    exp_done++;
    bus.data_TO_FIFO = d;
    bus.w_wr_en      = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.fifo_writing_done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    repeat (1 + hold) @(negedge clk);
    bus.w_wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    chk({name, "_count"}, 32'(bus.fifo_count), 32'd0);
    chk({name, "_empty"}, 32'(bus.fifo_empty), 32'd1);
    chk({name, "_dones"}, 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    int base;
    int d0;
    bit got;
    bus.w_wr_en      = 1'b0;
    bus.data_TO_FIFO = '0;

    repeat (3) @(negedge clk);
    chk("rst_done",  32'(bus.fifo_writing_done), 32'd0);
    chk("rst_txnew", 32'(bus.tx_new_data), 32'd0);
    chk("rst_txdata", 32'(bus.tx_data), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rst_full",  32'(bus.fifo_full), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word.
    send_word(48'h0000_1234_0ABC, 0);
    drain("single");

    // Held enable.
    peak_count = 0;
    send_word({16'h0, 32'($urandom)}, 20);
    drain("held");
    chk("held_peak", 32'(peak_count), 32'd1);

    // Fill with UART stalled.
    busy_force = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) send_word({16'($urandom), 32'($urandom)}, 0);
    chk("fill_count", 32'(bus.fifo_count), 32'd16);
    chk("fill_full",  32'(bus.fifo_full), 32'd1);
    push_expected(48'h0000_BEEF_1818);
    exp_done++;
    bus.data_TO_FIFO = 48'h0000_BEEF_1818;
    bus.w_wr_en      = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("full_no_done", 32'(done_cnt), 32'(d0));
    busy_force = 0;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.fifo_writing_done) begin
        got = 1;
        break;
      end
    end
    chk("full_done_later", 32'(got), 32'd1);
    @(negedge clk);
    bus.w_wr_en = 1'b0;
    drain("fill");

    // UART backpressure.
    busy_min = 50;
    busy_max = 50;
    for (int i = 0; i < 3; i++) send_word({16'($urandom), 32'($urandom)}, 0);
    drain("bp");

    // Reset mid-packet with three words queued.
    base = n_strobes;
    for (int i = 0; i < 4; i++) send_word({16'($urandom), 32'($urandom)}, 0);
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      if (n_strobes >= base + 3) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_reached", 32'(got), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstmid_txnew", 32'(bus.tx_new_data), 32'd0);
    chk("rstmid_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rstmid_count", 32'(bus.fifo_count), 32'd0);
    rst = 1'b1;
    busy_min = 0;
    busy_max = 0;
    exp_done = done_cnt;
    @(negedge clk);
    send_word({16'($urandom), 32'($urandom)}, 0);
    drain("post_rst");

    // Pointer wrap with random data and random UART busy.
    busy_min = 0;
    busy_max = 3;
    for (int i = 0; i < 40; i++) send_word({16'($urandom), 32'($urandom)}, 0);
    drain("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
